pipe_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB).
- Merges the load-use stall from the hazard unit with three other sources: EX branch redirect, MEM data-memory wait, and the multi-cycle MUL/DIV unit.
- Drives per-stage register enables and flushes.
- Mealy FSM: outputs are combinational from state plus inputs; state is registered.

---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/pipe_ctrl_if.sv | 43 ++++
 rtl/pipe_perf_cnt.sv | 32 +++
 rtl/pipe_ctrl.sv | 92 +++++++++
 tb/tb_pipe_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// Holds the FSM state encoding used by pipe_ctrl and its bus.
package pipe_ctrl_pkg;

   localparam int CTRL_STATE_W = 2;

   typedef enum logic [CTRL_STATE_W-1:0] {
      CTRL_RUN      = 2'd0,
      CTRL_MEM_WAIT = 2'd1,
      CTRL_MD_WAIT  = 2'd2
   } ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard requests into, and stage enables/flushes out of, pipe_ctrl.
// master drives the requests; slave is the sequencer side.
interface pipe_ctrl_if;
   import pipe_ctrl_pkg::*;

   logic                    load_use_i;
   logic                    branch_taken_ex_i;
   logic                    mem_req_i;
   logic                    mem_ack_i;
   logic                    md_start_i;
   logic                    md_done_i;
   logic                    pc_en_o;
   logic                    if_id_en_o;
   logic                    id_ex_en_o;
   logic                    ex_mem_en_o;
   logic                    mem_wb_en_o;
   logic                    if_id_flush_o;
   logic                    id_ex_flush_o;
   logic                    ex_mem_flush_o;
   logic                    mem_wb_flush_o;
   logic [CTRL_STATE_W-1:0] state_o;

   modport master (
      output load_use_i, branch_taken_ex_i, mem_req_i,
      output mem_ack_i, md_start_i, md_done_i,
      input  pc_en_o, if_id_en_o, id_ex_en_o,
      input  ex_mem_en_o, mem_wb_en_o,
      input  if_id_flush_o, id_ex_flush_o,
      input  ex_mem_flush_o, mem_wb_flush_o,
      input  state_o
   );

   modport slave (
      input  load_use_i, branch_taken_ex_i, mem_req_i,
      input  mem_ack_i, md_start_i, md_done_i,
      output pc_en_o, if_id_en_o, id_ex_en_o,
      output ex_mem_en_o, mem_wb_en_o,
      output if_id_flush_o, id_ex_flush_o,
      output ex_mem_flush_o, mem_wb_flush_o,
      output state_o
   );

endinterface

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module pipe_perf_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (inc_i && (cnt_q != '1))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (Mealy FSM).
// Define PIPE_CTRL_PERF_EN to add stall/redirect counters.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
`ifdef PIPE_CTRL_PERF_EN
#(
   parameter int CNT_W = 32
)
`endif
(
   input  logic             clk_i,
   input  logic             rst_i,
`ifdef PIPE_CTRL_PERF_EN
   output logic [CNT_W-1:0] stall_cyc_o,
   output logic [CNT_W-1:0] flush_cnt_o,
`endif
   pipe_ctrl_if.slave       bus
);

   ctrl_state_t state_d, state_q;
   logic        mem_hold, md_hold, redirect, lu_stall;

   always_comb begin
      state_d  = CTRL_RUN;
      mem_hold = 1'b0;
      md_hold  = 1'b0;
      redirect = 1'b0;
      lu_stall = 1'b0;
      case (state_q)
         CTRL_RUN, CTRL_MEM_WAIT: begin
            // a zero-wait access (ack with req) never stalls
            if (state_q == CTRL_MEM_WAIT)
               mem_hold = ~bus.mem_ack_i;
            else
               mem_hold = bus.mem_req_i & ~bus.mem_ack_i;
            if (!mem_hold) begin
               md_hold  = bus.md_start_i & ~bus.md_done_i;
               redirect = ~md_hold & bus.branch_taken_ex_i;
               lu_stall = ~md_hold & ~bus.branch_taken_ex_i
                        & bus.load_use_i;
            end
         end
         CTRL_MD_WAIT: begin
            md_hold  = ~bus.md_done_i;
            lu_stall = bus.md_done_i & bus.load_use_i;
         end
         default: ;
      endcase
      if (mem_hold)
         state_d = CTRL_MEM_WAIT;
      else if (md_hold)
         state_d = CTRL_MD_WAIT;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         state_q <= CTRL_RUN;
      else
         state_q <= state_d;
   end

   assign bus.pc_en_o     = ~(mem_hold | md_hold | lu_stall) & ~rst_i;
   assign bus.if_id_en_o  = ~(mem_hold | md_hold | lu_stall) & ~rst_i;
   assign bus.id_ex_en_o  = ~(mem_hold | md_hold) & ~rst_i;
   assign bus.ex_mem_en_o = ~mem_hold & ~rst_i;
   assign bus.mem_wb_en_o = ~rst_i;

   assign bus.if_id_flush_o  = redirect | rst_i;
   assign bus.id_ex_flush_o  = redirect | lu_stall | rst_i;
   assign bus.ex_mem_flush_o = md_hold | rst_i;
   assign bus.mem_wb_flush_o = mem_hold | rst_i;
   assign bus.state_o        = state_q;

`ifdef PIPE_CTRL_PERF_EN
   pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (1'b0),
      .inc_i (~bus.pc_en_o),
      .cnt_o (stall_cyc_o)
   );

   pipe_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (1'b0),
      .inc_i (redirect),
      .cnt_o (flush_cnt_o)
   );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed cases then random traffic.
// Expected stage actions come from a cause-level reference model.
module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;

   localparam int C_RESET = 0;
   localparam int C_IDLE  = 1;
   localparam int C_MEMW  = 2;
   localparam int C_MDW   = 3;
   localparam int C_RED   = 4;
   localparam int C_LU    = 5;
   localparam int CMAX    = 15;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;

   always #5 clk_i = ~clk_i;

   pipe_ctrl_if bus ();

`ifdef PIPE_CTRL_PERF_EN
   logic [3:0] stall_cyc_o, flush_cnt_o;
   pipe_ctrl #(.CNT_W(4)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .stall_cyc_o (stall_cyc_o),
      .flush_cnt_o (flush_cnt_o),
      .bus         (bus)
   );
`else
   pipe_ctrl dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );
`endif

   typedef struct {
      logic [10:0] v;
      int          cause;
      int          sc;
      int          fc;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad   = 0;
   int mst   = 0;
   int sc    = 0;
   int fc    = 0;

   // {pc,if_id,id_ex,ex_mem,mem_wb en, if_id,id_ex,ex_mem,mem_wb flush, state}
   function automatic logic [10:0] row(input int c, input logic [1:0] st);
      case (c)
         C_RESET: row = {5'b00000, 4'b1111, 2'd0};
         C_MEMW:  row = {5'b00001, 4'b0001, st};
         C_MDW:   row = {5'b00011, 4'b0010, st};
         C_RED:   row = {5'b11111, 4'b1100, st};
         C_LU:    row = {5'b00111, 4'b0100, st};
         default: row = {5'b11111, 4'b0000, st};
      endcase
   endfunction

   function automatic string cname(input int c);
      case (c)
         C_RESET: cname = "reset";
         C_MEMW:  cname = "mem_wait";
         C_MDW:   cname = "md_wait";
         C_RED:   cname = "redirect";
         C_LU:    cname = "load_use";
         default: cname = "idle";
      endcase
   endfunction

   task automatic step(input bit r, input bit lu, input bit br,
                       input bit mrq, input bit mak,
                       input bit mds, input bit mdd);
      exp_t e;
      int   c;
      @(posedge clk_i);
      #1;
      rst_i                 = r;
      bus.load_use_i        = lu;
      bus.branch_taken_ex_i = br;
      bus.mem_req_i         = mrq;
      bus.mem_ack_i         = mak;
      bus.md_start_i        = mds;
      bus.md_done_i         = mdd;
      if (r)
         c = C_RESET;
      else if (mst == 2)
         c = !mdd ? C_MDW : (lu ? C_LU : C_IDLE);
      else if ((mst == 1) ? !mak : (mrq && !mak))
         c = C_MEMW;
      else if (mds && !mdd)
         c = C_MDW;
      else if (br)
         c = C_RED;
      else if (lu)
         c = C_LU;
      else
         c = C_IDLE;
      if (r) begin
         sc = 0;
         fc = 0;
      end
      e.v     = row(c, r ? 2'd0 : 2'(mst));
      e.cause = c;
      e.sc    = sc;
      e.fc    = fc;
      q.push_back(e);
      if (!r && !e.v[10] && sc < CMAX) sc++;
      if (c == C_RED && fc < CMAX) fc++;
      mst = (c == C_MEMW) ? 1 : (c == C_MDW) ? 2 : 0;
   endtask

   always @(negedge clk_i) begin
      exp_t        e;
      logic [10:0] act;
      if (q.size() > 0) begin
         e   = q.pop_front();
         act = {bus.pc_en_o, bus.if_id_en_o, bus.id_ex_en_o,
                bus.ex_mem_en_o, bus.mem_wb_en_o,
                bus.if_id_flush_o, bus.id_ex_flush_o,
                bus.ex_mem_flush_o, bus.mem_wb_flush_o,
                bus.state_o};
         total++;
         if (act !== e.v) begin
            bad++;
            $display("FAIL %s: got=%b want=%b", cname(e.cause), act, e.v);
         end
`ifdef PIPE_CTRL_PERF_EN
         total++;
         if (int'(stall_cyc_o) != e.sc) begin
            bad++;
            $display("FAIL stall_cyc: got=%0d want=%0d", stall_cyc_o, e.sc);
         end
         total++;
         if (int'(flush_cnt_o) != e.fc) begin
            bad++;
            $display("FAIL flush_cnt: got=%0d want=%0d", flush_cnt_o, e.fc);
         end
`endif
      end
   end

   always @(negedge clk_i) begin
      if (!rst_i && bus.state_o == 2'd2)
         assert (!bus.mem_req_i) else $error("mem_req_i high in MD_WAIT");
   end

   initial begin
      bus.load_use_i        = 1'b0;
      bus.branch_taken_ex_i = 1'b0;
      bus.mem_req_i         = 1'b0;
      bus.mem_ack_i         = 1'b0;
      bus.md_start_i        = 1'b0;
      bus.md_done_i         = 1'b0;

      // reset with random inputs, then idle
      repeat (3)
         step(1, 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom));
      repeat (2) step(0, 0, 0, 0, 0, 0, 0);
      // single load-use bubble
      step(0, 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      // branch wins over load-use
      step(0, 1, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      // memory wait of 3 cycles, ack on the 4th
      repeat (3) step(0, 0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 1, 0, 0);
      // zero-wait access
      step(0, 0, 0, 1, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      // mul/div of 5 cycles, release with load-use
      repeat (5) step(0, 0, 0, 0, 0, 1, 0);
      step(0, 1, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0, 0, 0);
      // long stall saturates the stall counter, then reset mid-stall
      repeat (20) step(0, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 1, 0);
      repeat (2) step(0, 0, 0, 0, 0, 0, 0);
      // random traffic
      repeat (400) begin
         step(($urandom_range(0, 60) == 0),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 4) == 0),
              (mst != 2) && ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 2) == 0));
      end
      @(negedge clk_i);
      #1;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: got=%0d left want=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
